// File: rtl/ibex_data_responder.sv
// ibex_data_responder: in-order req/gnt/rvalid data-port responder backed by a local word SRAM
module ibex_data_responder #(
    parameter int unsigned DEPTH       = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [2:0]  WAIT  = 3'(WAIT_CYCLES);

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  cnt;
    } entry_t;

    logic [31:0] r_mem [DEPTH];
    entry_t      r_fifo [2];
    logic [1:0]  r_count;

    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_slot;
    entry_t        w_new;
    entry_t        w_dec0;
    entry_t        w_dec1;
    entry_t        w_next0;
    entry_t        w_next1;

    assign w_off      = addr_i - BASE_ADDR;
    assign w_in_range = (addr_i >= BASE_ADDR) && ({1'b0, w_off} < LIMIT);
    assign w_idx      = w_off[AW+1:2];
    assign w_pop      = (r_count != 2'd0) && (r_fifo[0].cnt == 3'd0);
    assign gnt_o      = req_i && ((r_count < 2'd2) || w_pop);
    assign w_push     = gnt_o;
    assign w_slot     = r_count - {1'b0, w_pop};

    // Entry 0 is always the head; a pop shifts entry 1 down while both age.
    always_comb begin
        w_new.rdata = (we_i || !w_in_range) ? 32'd0 : r_mem[w_idx];
        w_new.err   = !w_in_range;
        w_new.cnt   = WAIT;
        w_dec0      = r_fifo[0];
        w_dec0.cnt  = (r_fifo[0].cnt != 3'd0) ? r_fifo[0].cnt - 3'd1 : 3'd0;
        w_dec1      = r_fifo[1];
        w_dec1.cnt  = (r_fifo[1].cnt != 3'd0) ? r_fifo[1].cnt - 3'd1 : 3'd0;
        w_next0     = (w_push && w_slot == 2'd0) ? w_new : (w_pop ? w_dec1 : w_dec0);
        w_next1     = (w_push && w_slot == 2'd1) ? w_new : w_dec1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count   <= 2'd0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
        end else begin
            r_count   <= r_count - {1'b0, w_pop} + {1'b0, w_push};
            r_fifo[0] <= w_next0;
            r_fifo[1] <= w_next1;
        end
    end

    // Memory is never reset, so accepted writes survive a reset.
    always_ff @(posedge clk_i) begin
        if (w_push && we_i && w_in_range)
            for (int k = 0; k < 4; k++)
                if (be_i[k])
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end

    assign rvalid_o = w_pop;
    assign rdata_o  = w_pop ? r_fifo[0].rdata : 32'd0;
    assign err_o    = w_pop && r_fifo[0].err;
endmodule

// File: tb/tb_ibex_data_responder.sv
// tb_ibex_data_responder: directed checks of ibex_data_responder at WAIT_CYCLES 0, 2 and 3
module tb_ibex_data_responder;
    logic        clk;
    logic        rst_n;
    logic        req0, req2, req3;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt0, gnt2, gnt3;
    logic        rvalid0, rvalid2, rvalid3;
    logic [31:0] rdata0, rdata2, rdata3;
    logic        err0, err2, err3;
    int          checks = 0;
    int          failures = 0;

    ibex_data_responder #(.WAIT_CYCLES(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .gnt_o(gnt0), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
    );
    ibex_data_responder #(.WAIT_CYCLES(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );
    ibex_data_responder #(.WAIT_CYCLES(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r0, input logic r2, input logic r3, input logic w,
                       input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        req0 = r0; req2 = r2; req3 = r3; we = w; be = b; addr = a; wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) cyc;
        chk("rst_rvalid", 32'(rvalid0), 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_gnt", 32'(gnt0), 32'd1);
        cyc;
        req0 = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_gnt", 32'(gnt0), 32'd0);
        chk("rel_rvalid", 32'(rvalid0), 32'd0);
        cyc;
        chk("rel_rvalid_next", 32'(rvalid0), 32'd0);

        cyc; drv(1, 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF); #1;
        chk("be_gnt_w1", 32'(gnt0), 32'd1);
        cyc; drv(1, 0, 0, 1, 4'h2, 32'h10, 32'h00005500); #1;
        chk("be_gnt_w2", 32'(gnt0), 32'd1);
        chk("be_w1_rvalid", 32'(rvalid0), 32'd1);
        chk("be_w1_rdata", rdata0, 32'd0);
        cyc; drv(1, 0, 0, 0, 4'h0, 32'h10, 32'h0); #1;
        chk("be_w2_rvalid", 32'(rvalid0), 32'd1);
        chk("be_w2_rdata", rdata0, 32'd0);
        cyc; drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        chk("be_rd_rvalid", 32'(rvalid0), 32'd1);
        chk("be_rd_rdata", rdata0, 32'hDEAD55EF);
        chk("be_rd_err", 32'(err0), 32'd0);

        cyc; drv(1, 0, 0, 1, 4'hF, 32'h1FFC, 32'hCAFEF00D);
        cyc; drv(1, 0, 0, 0, 4'h0, 32'h2000, 32'h0);
        cyc; drv(1, 0, 0, 1, 4'hF, 32'h2000, 32'h12345678); #1;
        chk("oor_rd_err", 32'(err0), 32'd1);
        chk("oor_rd_rdata", rdata0, 32'd0);
        cyc; drv(1, 0, 0, 0, 4'h0, 32'h1FFC, 32'h0); #1;
        chk("oor_wr_rvalid", 32'(rvalid0), 32'd1);
        chk("oor_wr_err", 32'(err0), 32'd1);
        chk("oor_wr_rdata", rdata0, 32'd0);
        cyc; drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        chk("oor_last_rdata", rdata0, 32'hCAFEF00D);
        chk("oor_last_err", 32'(err0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            cyc; drv(1, 0, 0, 1, 4'hF, 32'(4 * i), 32'(i + 1));
        end
        for (int i = 0; i < 9; i++) begin
            cyc;
            if (i < 8) drv(1, 0, 0, 0, 4'h0, 32'(4 * i), 32'h0);
            else drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            #1;
            if (i < 8) chk($sformatf("b2b_gnt%0d", i), 32'(gnt0), 32'd1);
            chk($sformatf("b2b_rvalid%0d", i), 32'(rvalid0), 32'd1);
            chk($sformatf("b2b_rdata%0d", i), rdata0, (i == 0) ? 32'd0 : 32'(i));
        end

        cyc; drv(0, 1, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        chk("bp_t0_gnt", 32'(gnt2), 32'd1);
        chk("bp_t0_rvalid", 32'(rvalid2), 32'd0);
        cyc; #1;
        chk("bp_t1_gnt", 32'(gnt2), 32'd1);
        chk("bp_t1_rvalid", 32'(rvalid2), 32'd0);
        cyc; #1;
        chk("bp_t2_gnt", 32'(gnt2), 32'd0);
        chk("bp_t2_rvalid", 32'(rvalid2), 32'd0);
        cyc; #1;
        chk("bp_t3_gnt", 32'(gnt2), 32'd1);
        chk("bp_t3_rvalid", 32'(rvalid2), 32'd1);
        cyc; #1;
        chk("bp_t4_rvalid", 32'(rvalid2), 32'd1);
        cyc; drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (5) cyc;

        drv(0, 0, 1, 0, 4'h0, 32'h40, 32'h0); #1;
        chk("rmf_gnt_rd", 32'(gnt3), 32'd1);
        cyc; drv(0, 0, 1, 1, 4'hF, 32'h20, 32'hA5A5A5A5); #1;
        chk("rmf_gnt_wr", 32'(gnt3), 32'd1);
        cyc; drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); rst_n = 1'b0; #1;
        chk("rmf_in_rst", 32'(rvalid3), 32'd0);
        cyc; rst_n = 1'b1; #1;
        chk("rmf_release", 32'(rvalid3), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc;
            chk($sformatf("rmf_quiet%0d", k), 32'(rvalid3), 32'd0);
        end
        cyc; drv(0, 0, 1, 0, 4'h0, 32'h20, 32'h0); #1;
        chk("rmf_gnt_rd2", 32'(gnt3), 32'd1);
        cyc; drv(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        chk("rmf_wait1", 32'(rvalid3), 32'd0);
        cyc;
        chk("rmf_wait2", 32'(rvalid3), 32'd0);
        cyc;
        chk("rmf_wait3", 32'(rvalid3), 32'd0);
        cyc;
        chk("rmf_rvalid", 32'(rvalid3), 32'd1);
        chk("rmf_rdata", rdata3, 32'hA5A5A5A5);
        chk("rmf_err", 32'(err3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibex_data_responder.md
# ibex_data_responder

Memory-side responder for the Ibex core's data port (req/gnt/rvalid protocol). It terminates data requests in a local word-addressed SRAM array, with a configurable response latency and up to two requests in flight. Responses are returned strictly in order, and out-of-range accesses are flagged with `err_o`. It sits between `ibex_core`'s `data_*` port and the top level, replacing the direct single-port RAM hookup on the data side.

## Interface
Parameters:
- `DEPTH`, 2048: memory size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h00000000: byte address of word 0; aligned to 4*DEPTH.
- `WAIT_CYCLES`, 0: extra cycles between grant and rvalid; range 0..7.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request accepted this cycle.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in 4: byte enables for writes.
- `addr_i` in 32: byte address; bits [1:0] ignored.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid, exactly one per granted request.
- `rdata_o` out 32: read data; 0 for writes and errors.
- `err_o` out 1: response error, qualified by `rvalid_o`.

## Operation
- **Accept.** A request is accepted in cycle T when `req_i && gnt_o`.
  - `gnt_o = req_i && (count < 2 || pop)`, where `count` is the number of in-flight entries and `pop` is `rvalid_o` this cycle.
  - `gnt_o` is combinational from `req_i` and registered state only.
- **In range.** The address is in range when `BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH`. Word index = `(addr_i - BASE_ADDR)[log2(DEPTH)+1:2]`.
- **In-range write.** At the accept edge, byte k of the word is written with `wdata_i[8k+7:8k]` for each k where `be_i[k]` = 1. The response carries rdata 0, err 0.
- **In-range read.** The word is sampled at accept and stored in the response entry. The response carries the full 32 bits, err 0. `be_i` is ignored for reads.
- **Out of range.** No memory change. The response carries rdata 0, err 1.
- **Response FIFO.** 2 entries, each holding {rdata, err, cnt[2:0]}.
  - On accept, an entry is pushed with `cnt = WAIT_CYCLES`.
  - Every cycle, each valid entry with `cnt > 0` decrements.
  - `rvalid_o = !empty && head.cnt == 0`. `rdata_o` and `err_o` are driven from the head entry. The head pops in the same cycle.
  - Push and pop in the same cycle are allowed, and `count` stays unchanged.
- **Ordering.** Memory updates happen in accept order, so a read accepted after a write to the same word returns the written data (read-after-write consistent).
- **Reset state.**
  - FIFO empties, `count` = 0, and all counters clear.
  - `gnt_o` follows `req_i` (count = 0). `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0.
  - Memory contents are not reset.
- **Reset during operation.** In-flight responses are discarded and never delivered. Writes already accepted remain in memory.

## Timing
- Accept at T gives `rvalid_o` at T+1+WAIT_CYCLES, provided no earlier response is still pending. Otherwise it comes one cycle after the preceding response.
- With `WAIT_CYCLES` = 0: sustained throughput is 1 request per cycle, gnt never drops, and rvalid follows each accept by exactly 1 cycle.
- With `WAIT_CYCLES` = W > 0: at most 2 outstanding.
  - Accepts at T and T+1 give rvalids at T+1+W and T+2+W.
  - `gnt_o` is low from T+2 until T+1+W, where the pop re-enables it.
- `rvalid_o` never asserts in the cycle of reset release.
- No response is ever produced without a prior grant.

## Test plan
- **Reset.** Hold `rst_ni` = 0 with `req_i` = 1 → `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0, `gnt_o` = 1. Release reset with `req_i` = 0 → `gnt_o` = 0 and no rvalid.
- **Byte-enable write/read.**
  - Write 0xDEADBEEF to 0x10 with be = 4'hF, then write 0x00005500 with be = 4'h2.
  - Read 0x10 → rdata 0xDEAD55EF, err 0, at 1 cycle after grant (W = 0). Both write responses have rdata 0.
- **Out of range.**
  - Read `BASE_ADDR + 4*DEPTH` → err 1, rdata 0.
  - Write 0x12345678 to the same address, then read word DEPTH-1 → its contents are unchanged.
- **Back-to-back (W = 0).** 8 consecutive reads of 0x0..0x1C, preloaded with values 1..8 → `gnt_o` high every cycle; rvalid on 8 consecutive cycles with rdata 1..8 in order.
- **Backpressure (W = 2).** `req_i` held high for reads at T0 → grants at T0, T1; `gnt_o` = 0 at T2; rvalid at T3 and T4; the third grant comes at T3.
- **Reset mid-flight (W = 3).**
  - Grant a read and a write of 0xA5A5A5A5 to 0x20, then assert `rst_ni` = 0 one cycle later → no rvalid after reset.
  - A subsequent read of 0x20 returns 0xA5A5A5A5.
